// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types for the I/D memory arbiter
package mem_pkg;

    localparam int XLEN = 32;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    typedef struct packed {
        logic [XLEN-1:0]   addr;
        logic              we;
        logic [XLEN-1:0]   wdata;
        logic [XLEN/8-1:0] wstrb;
    } mem_req_t;

endpackage

// File: rtl/owner_fifo.sv
// rtl/owner_fifo.sv - in-order FIFO of transaction owners for response routing
module owner_fifo
    import mem_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push,
    input  owner_e        push_owner,
    input  logic          pop,
    output owner_e        head,
    output logic          empty,
    output logic          full,
    output logic [CW-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    owner_e        slots [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    // Explicit wrap so non-power-of-two depths (3) index correctly.
    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (push) begin
            slots[wr_ptr] <= push_owner;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= bump(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= bump(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign head  = slots[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

endmodule

// File: rtl/mem_arb2.sv
// rtl/mem_arb2.sv - two-requester (fetch/load-store) arbiter onto one memory port
module mem_arb2
    import mem_pkg::*;
#(
    parameter int OUTSTANDING = 2,
    parameter int D_PRIORITY  = 0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            i_req_valid,
    input  logic [XLEN-1:0] i_req_addr,
    output logic            i_req_ready,
    output logic            i_resp_valid,
    output logic [XLEN-1:0] i_resp_data,
    input  logic            i_resp_ready,
    input  logic            d_req_valid,
    input  logic [XLEN-1:0] d_req_addr,
    input  logic            d_req_we,
    input  logic [XLEN-1:0] d_req_wdata,
    input  logic [3:0]      d_req_wstrb,
    output logic            d_req_ready,
    output logic            d_resp_valid,
    output logic [XLEN-1:0] d_resp_data,
    input  logic            d_resp_ready,
    output logic            m_req_valid,
    output logic [XLEN-1:0] m_req_addr,
    output logic            m_req_we,
    output logic [XLEN-1:0] m_req_wdata,
    output logic [3:0]      m_req_wstrb,
    input  logic            m_req_ready,
    input  logic            m_resp_valid,
    input  logic [XLEN-1:0] m_resp_data,
    output logic            m_resp_ready,
    output logic            err_unexpected_resp
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_HOLD = 1'b1;
    localparam int         CW     = $clog2(OUTSTANDING + 1);

    logic [0:0]    state;
    owner_e        last_grant;
    owner_e        fifo_head;
    mem_req_t      req_q;
    mem_req_t      req_d;
    logic          fifo_empty;
    logic          fifo_full;
    logic [CW-1:0] fifo_count;
    logic          slot_free;
    logic          can_grant;
    logic          pick_d;
    logic          grant_i;
    logic          grant_d;
    logic          resp_hs;

    // Credits come from the registered count only, so a response in this cycle cannot fund a grant.
    assign slot_free = (state == S_IDLE) || m_req_ready;
    assign can_grant = slot_free && !fifo_full && (fifo_count < CW'(OUTSTANDING));
    assign pick_d    = d_req_valid && (!i_req_valid || (D_PRIORITY != 0) || (last_grant == OWN_I));
    assign grant_d   = can_grant && pick_d;
    assign grant_i   = can_grant && i_req_valid && !pick_d;

    assign i_req_ready = grant_i;
    assign d_req_ready = grant_d;

    always_comb begin
        req_d = '0;
        if (grant_d) begin
            req_d.addr  = d_req_addr;
            req_d.we    = d_req_we;
            req_d.wdata = d_req_wdata;
            req_d.wstrb = d_req_wstrb;
        end else begin
            req_d.addr  = i_req_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state               <= S_IDLE;
            req_q               <= '0;
            last_grant          <= OWN_D;
            err_unexpected_resp <= 1'b0;
        end else begin
            if (grant_i || grant_d) begin
                state      <= S_HOLD;
                req_q      <= req_d;
                last_grant <= grant_d ? OWN_D : OWN_I;
            end else if (m_req_ready) begin
                state      <= S_IDLE;
            end
            if (fifo_empty && m_resp_valid) begin
                err_unexpected_resp <= 1'b1;
            end
        end
    end

    assign m_req_valid = (state == S_HOLD);
    assign m_req_addr  = req_q.addr;
    assign m_req_we    = req_q.we;
    assign m_req_wdata = req_q.wdata;
    assign m_req_wstrb = req_q.wstrb;

    // With nothing in flight the port drains stray responses instead of stalling memory.
    always_comb begin
        i_resp_valid = 1'b0;
        d_resp_valid = 1'b0;
        m_resp_ready = 1'b1;
        if (!fifo_empty) begin
            if (fifo_head == OWN_D) begin
                d_resp_valid = m_resp_valid;
                m_resp_ready = d_resp_ready;
            end else begin
                i_resp_valid = m_resp_valid;
                m_resp_ready = i_resp_ready;
            end
        end
    end

    assign i_resp_data = m_resp_data;
    assign d_resp_data = m_resp_data;
    assign resp_hs     = m_resp_valid && m_resp_ready && !fifo_empty;

    owner_fifo #(
        .DEPTH      (OUTSTANDING)
    ) u_owner_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .push       (grant_i || grant_d),
        .push_owner (grant_d ? OWN_D : OWN_I),
        .pop        (resp_hs),
        .head       (fifo_head),
        .empty      (fifo_empty),
        .full       (fifo_full),
        .count      (fifo_count)
    );

endmodule

// File: tb/tb_mem_arb2.sv
// tb/tb_mem_arb2.sv - directed self-checking bench for mem_arb2
module tb_mem_arb2;

    typedef struct {
        int          due;
        logic [31:0] data;
    } rsp_t;

    localparam int LAT = 1;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        i_req_valid, i_req_ready, i_resp_valid, i_resp_ready;
    logic [31:0] i_req_addr, i_resp_data;
    logic        d_req_valid, d_req_we, d_req_ready, d_resp_valid, d_resp_ready;
    logic [31:0] d_req_addr, d_req_wdata, d_resp_data;
    logic [3:0]  d_req_wstrb;
    logic        m_req_valid, m_req_we, m_req_ready, m_resp_valid, m_resp_ready;
    logic [31:0] m_req_addr, m_req_wdata, m_resp_data;
    logic [3:0]  m_req_wstrb;
    logic        err_unexpected_resp;

    logic        p_i_req_ready, p_i_resp_valid, p_d_req_ready, p_d_resp_valid;
    logic [31:0] p_i_resp_data, p_d_resp_data, p_m_req_addr, p_m_req_wdata;
    logic        p_m_req_valid, p_m_req_we, p_m_resp_ready, p_err;
    logic [3:0]  p_m_req_wstrb;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    logic        auto_mem = 1'b0;
    rsp_t        mq [$];
    logic [31:0] exp_i [$];
    logic [31:0] exp_d [$];

    always #5 clk = ~clk;

    mem_arb2 #(.OUTSTANDING(2), .D_PRIORITY(0)) dut (
        .clk(clk), .reset_n(reset_n),
        .i_req_valid(i_req_valid), .i_req_addr(i_req_addr), .i_req_ready(i_req_ready),
        .i_resp_valid(i_resp_valid), .i_resp_data(i_resp_data), .i_resp_ready(i_resp_ready),
        .d_req_valid(d_req_valid), .d_req_addr(d_req_addr), .d_req_we(d_req_we),
        .d_req_wdata(d_req_wdata), .d_req_wstrb(d_req_wstrb), .d_req_ready(d_req_ready),
        .d_resp_valid(d_resp_valid), .d_resp_data(d_resp_data), .d_resp_ready(d_resp_ready),
        .m_req_valid(m_req_valid), .m_req_addr(m_req_addr), .m_req_we(m_req_we),
        .m_req_wdata(m_req_wdata), .m_req_wstrb(m_req_wstrb), .m_req_ready(m_req_ready),
        .m_resp_valid(m_resp_valid), .m_resp_data(m_resp_data), .m_resp_ready(m_resp_ready),
        .err_unexpected_resp(err_unexpected_resp)
    );

    mem_arb2 #(.OUTSTANDING(2), .D_PRIORITY(1)) dut_p (
        .clk(clk), .reset_n(reset_n),
        .i_req_valid(i_req_valid), .i_req_addr(i_req_addr), .i_req_ready(p_i_req_ready),
        .i_resp_valid(p_i_resp_valid), .i_resp_data(p_i_resp_data), .i_resp_ready(i_resp_ready),
        .d_req_valid(d_req_valid), .d_req_addr(d_req_addr), .d_req_we(d_req_we),
        .d_req_wdata(d_req_wdata), .d_req_wstrb(d_req_wstrb), .d_req_ready(p_d_req_ready),
        .d_resp_valid(p_d_resp_valid), .d_resp_data(p_d_resp_data), .d_resp_ready(d_resp_ready),
        .m_req_valid(p_m_req_valid), .m_req_addr(p_m_req_addr), .m_req_we(p_m_req_we),
        .m_req_wdata(p_m_req_wdata), .m_req_wstrb(p_m_req_wstrb), .m_req_ready(m_req_ready),
        .m_resp_valid(m_resp_valid), .m_resp_data(m_resp_data), .m_resp_ready(p_m_resp_ready),
        .err_unexpected_resp(p_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; when auto_mem is set, act as a fixed-latency in-order memory returning addr.
    task automatic tick();
        logic        rq, rs;
        logic [31:0] ra;
        @(negedge clk);
        rq = m_req_valid && m_req_ready;
        rs = m_resp_valid && m_resp_ready;
        ra = m_req_addr;
        @(posedge clk);
        #1;
        cyc++;
        if (auto_mem) begin
            if (rs && mq.size() > 0) mq.delete(0);
            if (rq) mq.push_back('{due: cyc + LAT - 1, data: ra});
            if (mq.size() > 0 && mq[0].due <= cyc) begin
                m_resp_valid = 1'b1;
                m_resp_data  = mq[0].data;
            end else begin
                m_resp_valid = 1'b0;
                m_resp_data  = '0;
            end
        end
    endtask

    task automatic mon_resp();
        check_eq("rr_resp_one_hot", 32'(i_resp_valid && d_resp_valid), 0);
        if (i_resp_valid) begin
            check_eq("rr_i_pending", 32'(exp_i.size() > 0), 1);
            if (exp_i.size() > 0) begin
                check_eq("rr_i_data", i_resp_data, exp_i[0]);
                exp_i.delete(0);
            end
        end
        if (d_resp_valid) begin
            check_eq("rr_d_pending", 32'(exp_d.size() > 0), 1);
            if (exp_d.size() > 0) begin
                check_eq("rr_d_data", d_resp_data, exp_d[0]);
                exp_d.delete(0);
            end
        end
        check_eq("prio_i_resp", 32'(p_i_resp_valid), 0);
        check_eq("prio_d_resp", 32'(p_d_resp_valid), 32'(m_resp_valid));
        check_eq("prio_m_resp_ready", 32'(p_m_resp_ready), 1);
        if (m_resp_valid) begin
            check_eq("prio_d_data", p_d_resp_data, m_resp_data);
            check_eq("prio_i_data", p_i_resp_data, m_resp_data);
        end
    endtask

    initial begin
        logic [31:0] ia, da;
        logic        last_d;
        int          gi, gd;

        reset_n = 1'b0;
        i_req_valid = 0; i_req_addr = 0; i_resp_ready = 0;
        d_req_valid = 0; d_req_addr = 0; d_req_we = 0; d_req_wdata = 0; d_req_wstrb = 0;
        d_resp_ready = 0; m_req_ready = 0; m_resp_valid = 0; m_resp_data = 0;
        tick();
        tick();
        #2;
        check_eq("rst_m_req_valid", 32'(m_req_valid), 0);
        check_eq("rst_m_req_addr", m_req_addr, 0);
        check_eq("rst_m_req_we", 32'(m_req_we), 0);
        check_eq("rst_m_req_wdata", m_req_wdata, 0);
        check_eq("rst_m_req_wstrb", 32'(m_req_wstrb), 0);
        check_eq("rst_err", 32'(err_unexpected_resp), 0);
        check_eq("rst_m_resp_ready", 32'(m_resp_ready), 1);

        // Single fetch
        reset_n = 1'b1;
        i_req_valid = 1; i_req_addr = 32'h4;
        #2;
        check_eq("f_i_ready", 32'(i_req_ready), 1);
        check_eq("f_d_ready", 32'(d_req_ready), 0);
        tick();
        i_req_valid = 0; m_req_ready = 1;
        #2;
        check_eq("f_m_valid", 32'(m_req_valid), 1);
        check_eq("f_m_addr", m_req_addr, 32'h4);
        check_eq("f_m_we", 32'(m_req_we), 0);
        check_eq("f_m_wstrb", 32'(m_req_wstrb), 0);
        tick();
        m_req_ready = 0; m_resp_valid = 1; m_resp_data = 32'h0050_0093;
        i_resp_ready = 1; d_resp_ready = 1;
        #2;
        check_eq("f_i_resp_valid", 32'(i_resp_valid), 1);
        check_eq("f_i_resp_data", i_resp_data, 32'h0050_0093);
        check_eq("f_d_resp_valid", 32'(d_resp_valid), 0);
        check_eq("f_m_idle", 32'(m_req_valid), 0);
        tick();
        m_resp_valid = 0;

        // Store held off by memory for three cycles
        d_req_valid = 1; d_req_addr = 32'h100; d_req_we = 1;
        d_req_wdata = 32'hDEAD_BEEF; d_req_wstrb = 4'hF;
        #2;
        check_eq("s_d_ready", 32'(d_req_ready), 1);
        tick();
        d_req_valid = 0; d_req_we = 0; d_req_wdata = 0; d_req_wstrb = 0;
        i_req_valid = 1; i_req_addr = 32'h8;
        for (int k = 0; k < 3; k++) begin
            #2;
            check_eq("s_m_valid", 32'(m_req_valid), 1);
            check_eq("s_m_addr", m_req_addr, 32'h100);
            check_eq("s_m_we", 32'(m_req_we), 1);
            check_eq("s_m_wdata", m_req_wdata, 32'hDEAD_BEEF);
            check_eq("s_m_wstrb", 32'(m_req_wstrb), 32'hF);
            check_eq("s_no_second_grant", 32'(i_req_ready), 0);
            tick();
        end
        i_req_valid = 0; m_req_ready = 1;
        #2;
        check_eq("s_m_valid_release", 32'(m_req_valid), 1);
        tick();
        m_resp_valid = 1; m_resp_data = 0;
        #2;
        check_eq("s_d_ack", 32'(d_resp_valid), 1);
        check_eq("s_i_quiet", 32'(i_resp_valid), 0);
        tick();
        m_resp_valid = 0;

        // Outstanding limit and response back-pressure
        i_req_valid = 1; i_req_addr = 32'h10;
        #2;
        check_eq("o_grant1", 32'(i_req_ready), 1);
        tick();
        i_req_addr = 32'h14;
        #2;
        check_eq("o_grant2", 32'(i_req_ready), 1);
        tick();
        i_req_addr = 32'h18;
        for (int k = 0; k < 4; k++) begin
            #2;
            check_eq("o_full_block", 32'(i_req_ready), 0);
            tick();
        end
        m_resp_valid = 1; m_resp_data = 32'h11;
        #2;
        check_eq("o_no_bypass", 32'(i_req_ready), 0);
        check_eq("o_resp1", i_resp_data, 32'h11);
        check_eq("o_resp1_valid", 32'(i_resp_valid), 1);
        tick();
        m_resp_data = 32'h22; i_resp_ready = 0;
        #2;
        check_eq("o_grant3", 32'(i_req_ready), 1);
        check_eq("o_stall_ready0", 32'(m_resp_ready), 0);
        check_eq("o_stall_valid0", 32'(i_resp_valid), 1);
        tick();
        i_req_valid = 0;
        #2;
        check_eq("o_stall_ready1", 32'(m_resp_ready), 0);
        check_eq("o_m_addr3", m_req_addr, 32'h18);
        tick();
        i_resp_ready = 1;
        #2;
        check_eq("o_release", 32'(m_resp_ready), 1);
        check_eq("o_resp2", i_resp_data, 32'h22);
        tick();
        m_resp_data = 32'h33;
        #2;
        check_eq("o_resp3_valid", 32'(i_resp_valid), 1);
        tick();
        m_resp_valid = 0; i_resp_ready = 0; d_resp_ready = 0;
        #2;
        check_eq("o_fifo_empty", 32'(m_resp_ready), 1);
        check_eq("o_no_err", 32'(err_unexpected_resp), 0);

        // Round-robin with both requesters always valid
        reset_n = 0;
        tick();
        reset_n = 1;
        auto_mem = 1; m_req_ready = 1; i_resp_ready = 1; d_resp_ready = 1;
        i_req_valid = 1; d_req_valid = 1;
        ia = 32'h1000; da = 32'h2000; last_d = 1'b1; gi = 0; gd = 0;
        for (int c = 0; c < 300 && gi + gd < 20; c++) begin
            i_req_addr = ia; d_req_addr = da;
            #2;
            check_eq("prio_i_blocked", 32'(p_i_req_ready), 0);
            if (i_req_ready || d_req_ready) begin
                check_eq("rr_alternate", 32'(d_req_ready), 32'(!last_d));
                check_eq("rr_one_grant", 32'(i_req_ready && d_req_ready), 0);
                check_eq("prio_d_wins", 32'(p_d_req_ready), 1);
                if (d_req_ready) begin
                    exp_d.push_back(da); da += 4; gd++;
                end else begin
                    exp_i.push_back(ia); ia += 4; gi++;
                end
                last_d = d_req_ready;
            end
            mon_resp();
            tick();
        end
        i_req_valid = 0; d_req_valid = 0;
        for (int c = 0; c < 10; c++) begin
            #2;
            mon_resp();
            tick();
        end
        check_eq("rr_i_grants", gi, 10);
        check_eq("rr_d_grants", gd, 10);
        check_eq("rr_i_drained", exp_i.size(), 0);
        check_eq("rr_d_drained", exp_d.size(), 0);

        // Priority instance: I only while D is idle, then D wins the tie
        i_req_valid = 1; i_req_addr = 32'h40;
        #2;
        check_eq("prio_i_alone", 32'(p_i_req_ready), 1);
        tick();
        d_req_valid = 1; d_req_addr = 32'h300; d_req_we = 1;
        d_req_wdata = 32'h1234_5678; d_req_wstrb = 4'h3;
        #2;
        check_eq("prio_tie_d", 32'(p_d_req_ready), 1);
        check_eq("prio_tie_i", 32'(p_i_req_ready), 0);
        tick();
        i_req_valid = 0; d_req_valid = 0; d_req_we = 0;
        #2;
        check_eq("prio_m_valid", 32'(p_m_req_valid), 1);
        check_eq("prio_m_addr", p_m_req_addr, 32'h300);
        check_eq("prio_m_we", 32'(p_m_req_we), 1);
        check_eq("prio_m_wdata", p_m_req_wdata, 32'h1234_5678);
        check_eq("prio_m_wstrb", 32'(p_m_req_wstrb), 32'h3);
        for (int c = 0; c < 10; c++) tick();
        check_eq("prio_no_err", 32'(p_err), 0);
        check_eq("rr_no_err", 32'(err_unexpected_resp), 0);

        // Stray response with nothing in flight
        auto_mem = 0; m_resp_valid = 0;
        tick();
        m_resp_valid = 1; m_resp_data = 32'hBAD0_0001;
        #2;
        check_eq("e_drain_ready", 32'(m_resp_ready), 1);
        check_eq("e_not_yet", 32'(err_unexpected_resp), 0);
        tick();
        m_resp_valid = 0;
        #2;
        check_eq("e_set", 32'(err_unexpected_resp), 1);
        tick();
        tick();
        check_eq("e_sticky", 32'(err_unexpected_resp), 1);
        reset_n = 0;
        #2;
        check_eq("e_sync_reset_wait", 32'(err_unexpected_resp), 1);
        tick();
        check_eq("e_cleared", 32'(err_unexpected_resp), 0);
        reset_n = 1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
